i2c_master_ctrl: RTL and testbench
==================================

Name: i2c_master_ctrl

Overview:
- Byte-oriented I2C master driven by the register file's I2C mirror fields: register address and go bit (reg6), slave address (reg7[7:0]) and transmit byte (reg7[15:8]).
- Executes one register write or one register read per go request on an open-drain SCL/SDA pair.
- Reports status and read data back through the register file's I2C write port.

Parameters:
- CLK_DIV, 125, clk cycles per SCL quarter-period (50 MHz / (4*125) = 100 kHz); legal range 2..4095.

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- i2c_addr  input  9  [7:0] device register address; [8] go bit
- i2c_slave_addr  input  8  [7:1] 7-bit slave address; [0] 1 = read, 0 = write
- i2c_tx_data  input  8  byte to write (from reg_file_to_i2c_data)
- i2c_wr_en  output  1  one-cycle strobe; register file captures i2c_sts and i2c_rd_data
- i2c_sts  output  2  [1] nack_err; [0] busy
- i2c_rd_data  output  8  to i2c_to_reg_file_data
- scl_in  input  1  SCL pad level (pre-synchronised)
- sda_in  input  1  SDA pad level (pre-synchronised)
- scl_oe  output  1  1 = drive SCL low, 0 = release
- sda_oe  output  1  1 = drive SDA low, 0 = release

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
  - On reset: scl_oe=0, sda_oe=0, i2c_wr_en=0, i2c_sts=0, i2c_rd_data=0, state IDLE, go_d=0.
  - Reset mid-transaction releases both lines on the next edge; no STOP is generated.
- Go detection:
  - go_d registers i2c_addr[8] every cycle.
  - A start request is i2c_addr[8] & ~go_d while in IDLE. Requests while busy are ignored.
- Accept cycle (cycle after the request is seen):
  - Latch address, slave address and tx data.
  - Pulse i2c_wr_en with i2c_sts=01 and i2c_rd_data = latched tx data, so reg7[15:8] is unchanged.
- Completion:
  - Pulse i2c_wr_en once with i2c_sts={nack_err,0}.
  - i2c_rd_data = received byte on a successful read, otherwise the latched tx data.
  - Writing busy=0 clears reg6[8], re-arming the go edge detector.
- Timing: a tick fires every CLK_DIV cycles. Each bit is 4 quarters:
  - q0: SCL low, SDA set.
  - q1: SCL low.
  - q2: SCL released; SDA sampled at end of q2.
  - q3: SCL high.
- Clock stretching: in q2/q3, if scl_oe=0 and scl_in=0, the divider holds.
- States: IDLE -> START -> TX_BYTE -> ACK_RX -> (next byte | RSTART | RX_BYTE | STOP) -> DONE -> IDLE.
  - START: q0-q1 both released; q2-q3 SDA low with SCL high.
  - TX_BYTE: 8 bits, MSB first; sda_oe = ~bit.
  - ACK_RX: SDA released; sampled 1 = NACK.
  - Write sequence: START, {slave[7:1],0}, ACK, reg addr, ACK, tx byte, ACK, STOP.
  - Read sequence: START, {slave[7:1],0}, ACK, reg addr, ACK, RSTART, {slave[7:1],1}, ACK, RX_BYTE (8 bits, SDA released, MSB first), master NACK (SDA released), STOP.
  - RSTART:
    - q0: SCL low, SDA released.
    - q1: SDA released, SCL low.
    - q2: SCL released.
    - q3: SDA low.
  - STOP:
    - q0: SCL low, SDA low.
    - q1: SCL released.
    - q2: SDA released.
    - q3: idle.
- NACK on any ACK slot: set nack_err, go to STOP, then DONE.
- Bit counter is 3 bits and wraps after 7; a byte counter selects the next byte.
- Write transaction length: 4 + 27*4 + 4 = 116 quarters.

Test Plan:
- Write, all ACK (CLK_DIV=4, slave 0x50, addr 0x12, data 0xA5, go 0->1):
  - Accept strobe: sts=01, rd_data=0xA5.
  - Bus bytes: 0xA0, 0x12, 0xA5.
  - Final strobe: sts=00, rd_data=0xA5, 116*4 cycles after accept (±2).
- Read (slave byte 0xA1, addr 0x05, slave model returns 0x3C):
  - Bus sequence includes a repeated START and 0xA1.
  - Master NACKs the data byte.
  - Final strobe: sts=00, rd_data=0x3C.
- Address NACK (no slave): final strobe sts=10 after STOP; only the first byte is transmitted.
- Go held high through completion, then go toggled while busy: no second transaction until go falls and rises again.
- Clock stretching: slave holds SCL low 20 cycles in bit 3 of byte 2 -> divider frozen, bit period extended by exactly 20 cycles, data intact.
- rst asserted mid-byte 2: next edge gives scl_oe=sda_oe=0, sts=00, wr_en=0; a new go then completes normally.

Source files
------------

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: byte-oriented I2C master doing one register write or read per go edge
module i2c_master_ctrl #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] i2c_addr,
  input  logic [7:0] i2c_slave_addr,
  input  logic [7:0] i2c_tx_data,
  output logic       i2c_wr_en,
  output logic [1:0] i2c_sts,
  output logic [7:0] i2c_rd_data,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe
);
  typedef enum logic [2:0] {IDLE, START, TX_BYTE, ACK_RX, RSTART, RX_BYTE, STOP, DONE} state_t;
  state_t      r_state, w_next;
  logic [11:0] r_div;
  logic [1:0]  r_q, r_byte, w_byte_n, r_sts;
  logic [2:0]  r_bit;
  logic [7:0]  r_addr, r_slv, r_tx, r_sh, r_rx, r_rd, w_sh_n;
  logic        r_go_d, r_nack, r_samp, r_wr_en, w_nack_n;
  logic        w_busy, w_hold, w_tick, w_qend, w_req;
  assign w_busy = r_state != IDLE && r_state != DONE;
  // a slave holding SCL low while we release it freezes the quarter divider
  assign w_hold = w_busy && r_q[1] && !scl_oe && !scl_in;
  assign w_tick = w_busy && !w_hold && r_div == 12'(CLK_DIV - 1);
  assign w_qend = w_tick && &r_q;
  assign w_req  = r_state == IDLE && i2c_addr[8] && !r_go_d;
  assign i2c_wr_en   = r_wr_en;
  assign i2c_sts     = r_sts;
  assign i2c_rd_data = r_rd;
  always_comb begin
    w_next   = r_state;
    w_sh_n   = {r_sh[6:0], 1'b0};
    w_byte_n = r_byte;
    w_nack_n = r_nack;
    scl_oe   = 1'b0;
    sda_oe   = 1'b0;
    case (r_state)
      IDLE: w_next = w_req ? START : IDLE;
      START: begin
        sda_oe = r_q[1];
        if (w_qend) begin
          w_next = TX_BYTE;
          w_sh_n = {r_slv[7:1], 1'b0};
        end
      end
      TX_BYTE: begin
        scl_oe = ~r_q[1];
        sda_oe = ~r_sh[7];
        if (w_qend && r_bit == 3'd7) w_next = ACK_RX;
      end
      ACK_RX: begin
        scl_oe = ~r_q[1];
        if (w_qend) begin
          w_byte_n = r_byte + 2'd1;
          // byte 3 is the master's own NACK after read data, so its sample is ignored
          if (r_samp && r_byte != 2'd3) begin
            w_nack_n = 1'b1;
            w_next   = STOP;
          end else begin
            case (r_byte)
              2'd0: begin w_next = TX_BYTE; w_sh_n = r_addr; end
              2'd1: begin w_next = r_slv[0] ? RSTART : TX_BYTE; w_sh_n = r_tx; end
              2'd2: w_next = r_slv[0] ? RX_BYTE : STOP;
              default: w_next = STOP;
            endcase
          end
        end
      end
      RSTART: begin
        scl_oe = ~r_q[1];
        sda_oe = &r_q;
        if (w_qend) begin
          w_next = TX_BYTE;
          w_sh_n = {r_slv[7:1], 1'b1};
        end
      end
      RX_BYTE: begin
        scl_oe = ~r_q[1];
        if (w_qend && r_bit == 3'd7) w_next = ACK_RX;
      end
      STOP: begin
        scl_oe = r_q == 2'd0;
        sda_oe = ~r_q[1];
        if (w_qend) w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_q     <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_addr  <= '0;
      r_slv   <= '0;
      r_tx    <= '0;
      r_sh    <= '0;
      r_rx    <= '0;
      r_go_d  <= 1'b0;
      r_nack  <= 1'b0;
      r_samp  <= 1'b0;
      r_wr_en <= 1'b0;
      r_sts   <= '0;
      r_rd    <= '0;
    end else begin
      r_state <= w_next;
      r_go_d  <= i2c_addr[8];
      r_wr_en <= w_req || r_state == DONE;
      if (w_req) begin
        r_addr <= i2c_addr[7:0];
        r_slv  <= i2c_slave_addr;
        r_tx   <= i2c_tx_data;
        r_sts  <= 2'b01;
        r_rd   <= i2c_tx_data;
        r_nack <= 1'b0;
        r_div  <= '0;
        r_q    <= '0;
        r_bit  <= '0;
        r_byte <= '0;
      end else begin
        r_div <= (w_tick || !w_busy) ? '0 : r_div + {11'b0, ~w_hold};
        r_q   <= r_q + {1'b0, w_tick};
        if (w_tick && r_q == 2'd2) r_samp <= sda_in;
        if (w_tick && r_q == 2'd2 && r_state == RX_BYTE) r_rx <= {r_rx[6:0], sda_in};
        if (w_qend) begin
          r_sh   <= w_sh_n;
          r_byte <= w_byte_n;
          r_nack <= w_nack_n;
          r_bit  <= r_bit + 3'(r_state == TX_BYTE || r_state == RX_BYTE);
        end
        if (r_state == DONE) begin
          r_sts <= {r_nack, 1'b0};
          r_rd  <= (r_slv[0] && !r_nack) ? r_rx : r_tx;
        end
      end
    end
  end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: open-drain bus with a behavioural slave/monitor and a transaction-level expectation model
module tb_i2c_master_ctrl;
  localparam int DIV = 4;
  localparam int EV_S = 256, EV_P = 257, EV_A = 258, EV_N = 259;
  localparam logic [6:0] SLV = 7'h50;
  logic       clk = 1'b0, rst = 1'b1;
  logic [8:0] i2c_addr = '0;
  logic [7:0] i2c_slave_addr = '0, i2c_tx_data = '0;
  logic       i2c_wr_en, scl_oe, sda_oe, scl_in, sda_in;
  logic [1:0] i2c_sts;
  logic [7:0] i2c_rd_data;
  logic       s_scl = 1'b0, s_sda = 1'b0, stretch_req = 1'b0;
  logic [7:0] rd_byte = '0;
  int n_tests = 0, n_fail = 0, cyc = 0, wr_cnt = 0, dur = 0, base_dur = 0;
  int bus_q[$];
  assign scl_in = ~scl_oe & ~s_scl;
  assign sda_in = ~sda_oe & ~s_sda;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (i2c_wr_en) wr_cnt <= wr_cnt + 1;
  end
  i2c_master_ctrl #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .i2c_addr(i2c_addr), .i2c_slave_addr(i2c_slave_addr),
    .i2c_tx_data(i2c_tx_data), .i2c_wr_en(i2c_wr_en), .i2c_sts(i2c_sts),
    .i2c_rd_data(i2c_rd_data), .scl_in(scl_in), .sda_in(sda_in),
    .scl_oe(scl_oe), .sda_oe(sda_oe)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  // slave at address SLV: logs START/STOP/bytes/ACK levels, acks its address, serves rd_byte
  logic p_scl = 1'b1, p_sda = 1'b1, p_oe = 1'b0, rd = 1'b0;
  logic [7:0] sh = '0;
  int nb = 0, bi = 0, hold = 0;
  always @(negedge clk) begin
    logic scl_w, sda_w;
    if (rst) begin
      s_scl = 1'b0; s_sda = 1'b0; nb = 0; bi = 0; rd = 1'b0; hold = 0;
    end else if (hold > 0) begin
      hold--;
      if (hold == 0) s_scl = 1'b0;
    end else if (stretch_req && bi == 1 && nb == 3 && p_oe && !scl_oe) begin
      s_scl = 1'b1; hold = 20; stretch_req = 1'b0;
    end
    scl_w = ~scl_oe & ~s_scl;
    sda_w = ~sda_oe & ~s_sda;
    if (!rst) begin
      if (p_scl && scl_w && p_sda && !sda_w) begin
        bus_q.push_back(EV_S); nb = 0; bi = 0; rd = 1'b0;
      end else if (p_scl && scl_w && !p_sda && sda_w) begin
        bus_q.push_back(EV_P); rd = 1'b0; s_sda = 1'b0;
      end else if (!p_scl && scl_w) begin
        if (nb < 8) sh = {sh[6:0], sda_w};
        else begin
          bus_q.push_back(sda_w ? EV_N : EV_A);
          if (rd && sda_w) rd = 1'b0;
        end
        nb++;
        if (nb == 8) bus_q.push_back(int'(sh));
        if (nb == 9) begin nb = 0; bi++; end
      end else if (p_scl && !scl_w) begin
        if (nb == 8) begin
          if (rd) s_sda = 1'b0;
          else begin
            s_sda = bi > 0 || sh[7:1] == SLV;
            if (bi == 0 && s_sda && sh[0]) rd = 1'b1;
          end
        end else s_sda = rd && !rd_byte[7 - nb];
      end
    end
    p_scl = scl_w; p_sda = sda_w; p_oe = scl_oe;
  end
  task automatic wait_wr(input string tag, output int at);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!i2c_wr_en && n < 3000);
    check(tag, i2c_wr_en, 1'b1);
    at = cyc;
  endtask
  task automatic run_txn(input logic [6:0] sa, input logic rw, input logic [7:0] ra, td, rb,
                         input logic keep_go, input logic toggle, input int extra);
    int exp_q[$];
    int t0, t1, q, nbytes, lo, hi, got;
    logic ok;
    ok = sa == SLV;
    nbytes = !ok ? 1 : rw ? 4 : 3;
    q = 8 + 36 * nbytes + ((ok && rw) ? 4 : 0);
    exp_q.push_back(EV_S); exp_q.push_back(int'({sa, 1'b0}));
    if (!ok) exp_q.push_back(EV_N);
    else begin
      exp_q.push_back(EV_A); exp_q.push_back(int'(ra)); exp_q.push_back(EV_A);
      if (rw) begin
        exp_q.push_back(EV_S); exp_q.push_back(int'({sa, 1'b1})); exp_q.push_back(EV_A);
        exp_q.push_back(int'(rb)); exp_q.push_back(EV_N);
      end else begin
        exp_q.push_back(int'(td)); exp_q.push_back(EV_A);
      end
    end
    exp_q.push_back(EV_P);
    @(negedge clk);
    bus_q.delete();
    rd_byte = rb;
    i2c_slave_addr = {sa, rw};
    i2c_tx_data = td;
    i2c_addr = {1'b1, ra};
    wait_wr("accept_strobe", t0);
    check("accept_sts", i2c_sts, 2'b01);
    check("accept_rd", i2c_rd_data, td);
    @(negedge clk);
    check("accept_pulse", i2c_wr_en, 1'b0);
    if (toggle) begin
      repeat (50) @(negedge clk);
      i2c_addr[8] = 1'b0;
      @(negedge clk);
      i2c_addr[8] = 1'b1;
    end
    wait_wr("final_strobe", t1);
    dur = t1 - t0;
    check("final_sts", i2c_sts, ok ? 2'b00 : 2'b10);
    check("final_rd", i2c_rd_data, (ok && rw) ? rb : td);
    lo = 4 * q + extra - 2;
    hi = 4 * q + extra + 2;
    got = (dur >= lo && dur <= hi) ? 4 * q + extra : dur;
    check("duration", got, 4 * q + extra);
    if (!keep_go) i2c_addr[8] = 1'b0;
    @(negedge clk);
    check("final_pulse", i2c_wr_en, 1'b0);
    check("bus_len", bus_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("bus_ev%0d", i), i < bus_q.size() ? bus_q[i] : -1, exp_q[i]);
  endtask
  initial begin
    int w0, n;
    repeat (3) @(negedge clk);
    check("rst_scl_oe", scl_oe, 1'b0);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_wr_en", i2c_wr_en, 1'b0);
    check("rst_sts", i2c_sts, 2'b00);
    check("rst_rd", i2c_rd_data, 8'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_txn(SLV, 1'b0, 8'h12, 8'hA5, 8'h00, 1'b0, 1'b0, 0);
    base_dur = dur;
    run_txn(SLV, 1'b1, 8'h05, 8'h77, 8'h3C, 1'b0, 1'b0, 0);
    run_txn(7'h21, 1'b0, 8'h40, 8'h99, 8'h00, 1'b0, 1'b0, 0);
    // go held high and toggled while busy must not start another transfer
    run_txn(SLV, 1'b0, 8'h34, 8'h5C, 8'h00, 1'b1, 1'b1, 0);
    bus_q.delete();
    w0 = wr_cnt;
    repeat (200) @(negedge clk);
    check("held_go_no_strobe", wr_cnt, w0);
    check("held_go_bus_quiet", bus_q.size(), 0);
    i2c_addr[8] = 1'b0;
    run_txn(SLV, 1'b0, 8'h56, 8'hC3, 8'h00, 1'b0, 1'b0, 0);
    stretch_req = 1'b1;
    run_txn(SLV, 1'b0, 8'h12, 8'hA5, 8'h00, 1'b0, 1'b0, 20);
    check("stretch_extra", dur - base_dur, 20);
    // reset in the middle of the register-address byte
    @(negedge clk);
    i2c_slave_addr = {SLV, 1'b0};
    i2c_tx_data = 8'h5A;
    i2c_addr = {1'b1, 8'h33};
    n = 0;
    while (bus_q.size() < 3 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_first_ack", bus_q.size() >= 3, 1'b1);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    i2c_addr[8] = 1'b0;
    @(negedge clk);
    check("midrst_scl_oe", scl_oe, 1'b0);
    check("midrst_sda_oe", sda_oe, 1'b0);
    check("midrst_sts", i2c_sts, 2'b00);
    check("midrst_wr_en", i2c_wr_en, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_txn(SLV, 1'b0, 8'h33, 8'h5A, 8'h00, 1'b0, 1'b0, 0);
    for (int k = 0; k < 8; k++) begin
      logic [6:0] sa;
      sa = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SLV;
      run_txn(sa, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
